// File: rtl/seq_convolver.sv
// seq_convolver: full linear convolution y = h * x with one MAC; CONV_WRAP_COMPAT_EN truncates y to DATA_W bits.
// Latency: first y H_LEN+1 cycles after the final sample edge, then H_LEN+1 cycles after each output handshake.
// Backpressure: out_data/out_last held until out_ready; no samples accepted while computing or emitting.
module seq_convolver #(
  parameter int DATA_W = 4,
  parameter int COEF_W = 4,
  parameter int X_LEN  = 8,
  parameter int H_LEN  = 8,
  localparam int AW    = (H_LEN > 1) ? $clog2(H_LEN) : 1,
  localparam int ACC_W = DATA_W + COEF_W + $clog2(H_LEN) + 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              coef_we_i,
  input  logic [AW-1:0]     coef_addr_i,
  input  logic [COEF_W-1:0] coef_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ACC_W-1:0]  out_data_o,
  output logic              out_last_o,
  output logic              busy_o
);

  localparam int N_OUT = X_LEN + H_LEN - 1;
  localparam int XW    = (X_LEN > 1) ? $clog2(X_LEN) : 1;
  localparam int KW    = $clog2(H_LEN + 1);
  localparam int NW    = $clog2(N_OUT + 1);
  localparam int PW    = DATA_W + COEF_W;

  typedef enum logic [1:0] {IDLE, FILL, MAC, EMIT} state_t;

  state_t            state_q, state_d;
  logic [COEF_W-1:0] h_q [H_LEN];
  logic [DATA_W-1:0] x_q [X_LEN];
  logic [XW-1:0]     i_q;
  logic [KW-1:0]     k_q;
  logic [NW-1:0]     n_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  out_data_q;
  logic              out_valid_q;
  logic              out_last_q;

  logic              in_hs, out_hs, frame_done, last_term, last_out;
  logic [PW-1:0]     term;
  logic [31:0]       nk;
  logic [ACC_W-1:0]  acc_out;

`ifdef CONV_WRAP_COMPAT_EN
  localparam logic [ACC_W-1:0] WRAP_MASK = ACC_W'((1 << DATA_W) - 1);
  assign acc_out = acc_q & WRAP_MASK;
`else
  assign acc_out = acc_q;
`endif

  assign in_ready_o  = rst_n_i && ((state_q == IDLE) || (state_q == FILL));
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

  assign in_hs      = in_valid_i && in_ready_o;
  assign out_hs     = out_valid_q && out_ready_i;
  assign frame_done = in_last_i ||
                      ((state_q == IDLE) ? (X_LEN == 1) : (32'(i_q) == X_LEN - 1));
  assign last_term  = (32'(k_q) == H_LEN);
  assign last_out   = (32'(n_q) == N_OUT - 1);

  // Term k of y[n]; taps that fall outside the frame contribute zero.
  always_comb begin
    term = '0;
    nk   = 32'(n_q) - 32'(k_q);
    if ((32'(k_q) < H_LEN) && (32'(n_q) >= 32'(k_q)) && (nk < X_LEN))
      term = PW'(h_q[k_q[AW-1:0]]) * PW'(x_q[nk[XW-1:0]]);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_hs) state_d = frame_done ? MAC : FILL;
      FILL:    if (in_hs && frame_done) state_d = MAC;
      MAC:     if (last_term) state_d = EMIT;
      EMIT:    if (out_hs) state_d = last_out ? IDLE : MAC;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int j = 0; j < H_LEN; j++) h_q[j] <= '0;
      for (int j = 0; j < X_LEN; j++) x_q[j] <= '0;
      i_q         <= '0;
      k_q         <= '0;
      n_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (coef_we_i && (32'(coef_addr_i) < H_LEN)) h_q[coef_addr_i] <= coef_data_i;
          // Clearing the whole frame up front gives zero-fill for short frames.
          if (in_hs) begin
            for (int j = 1; j < X_LEN; j++) x_q[j] <= '0;
            x_q[0] <= in_data_i;
            i_q    <= XW'(1);
            n_q    <= '0;
            k_q    <= '0;
            acc_q  <= '0;
          end
        end
        FILL: begin
          if (in_hs) begin
            x_q[i_q] <= in_data_i;
            i_q      <= i_q + 1'b1;
          end
        end
        MAC: begin
          if (last_term) begin
            out_data_q  <= acc_out;
            out_valid_q <= 1'b1;
            out_last_q  <= last_out;
          end else begin
            acc_q <= acc_q + ACC_W'(term);
            k_q   <= k_q + 1'b1;
          end
        end
        EMIT: begin
          if (out_hs) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            acc_q       <= '0;
            k_q         <= '0;
            n_q         <= last_out ? '0 : n_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_convolver.sv
// Randomised and directed frames checked against a sum-of-products convolution model.
module tb_seq_convolver;

  localparam int DATA_W = 4;
  localparam int COEF_W = 4;
  localparam int X_LEN  = 8;
  localparam int H_LEN  = 8;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(H_LEN) + 1;
  localparam int N_OUT  = X_LEN + H_LEN - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              coef_we;
  logic [2:0]        coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_last;
  logic              busy;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int acc_edge;
  int hs [H_LEN];
  int xs [X_LEN];
  int exp_y [N_OUT];

  seq_convolver #(.DATA_W(DATA_W), .COEF_W(COEF_W), .X_LEN(X_LEN), .H_LEN(H_LEN)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_data_i(coef_data),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_last_o(out_last), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic build_model();
    for (int n = 0; n < N_OUT; n++) exp_y[n] = 0;
    for (int i = 0; i < X_LEN; i++)
      for (int k = 0; k < H_LEN; k++)
        exp_y[i + k] += hs[k] * xs[i];
`ifdef CONV_WRAP_COMPAT_EN
    for (int n = 0; n < N_OUT; n++) exp_y[n] = exp_y[n] % (1 << DATA_W);
`endif
  endtask

  task automatic load_coefs();
    for (int k = 0; k < H_LEN; k++) begin
      @(negedge clk);
      coef_we = 1'b1; coef_addr = 3'(k); coef_data = 4'(hs[k]);
    end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit gaps);
    int i = 0;
    int guard = 0;
    for (int j = len; j < X_LEN; j++) xs[j] = 0;
    build_model();
    while (i < len) begin
      @(negedge clk);
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        in_valid = 1'b0; in_last = 1'b0; in_data = 4'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = 4'(xs[i]);
        in_last  = (i == len - 1) && ((len < X_LEN) || ($urandom_range(0, 1) == 1));
        chk("in_ready while loading", in_ready, 1);
        if (in_ready) begin
          acc_edge = cyc + 1;
          i++;
        end
      end
      if (++guard > 100) begin
        chk("in_ready timeout", 0, 1);
        return;
      end
    end
  endtask

  // rnd_stall: random hold per output; otherwise hold stall_len cycles on y[stall_n].
  // abort_n >= 0 pulses rst_n while y[abort_n] is presented.
  task automatic recv_frame(input int stall_n, input int stall_len, input bit rnd_stall,
                            input bit poke_coef, input int abort_n);
    int n = 0;
    int wait_c = 0;
    int stall = 0;
    int ref_edge = acc_edge;
    bit seen = 1'b0;
    while (n < N_OUT) begin
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; coef_we = 1'b0;
      if (poke_coef && (n == 2)) begin
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 4'd7;
      end
      if (!out_valid) begin
        out_ready = 1'($urandom_range(0, 1));
        if (++wait_c > 4 * H_LEN + 20) begin
          chk("out_valid timeout", 0, 1);
          return;
        end
      end else if (!seen) begin
        seen = 1'b1; wait_c = 0;
        chk("output latency", cyc - ref_edge, H_LEN + 1);
        chk("y", out_data, exp_y[n]);
        chk("out_last", out_last, (n == N_OUT - 1));
        chk("busy while emitting", busy, 1);
        stall = rnd_stall ? $urandom_range(0, 2) : ((n == stall_n) ? stall_len : 0);
      end else begin
        chk("held y", out_data, exp_y[n]);
        chk("held out_last", out_last, (n == N_OUT - 1));
      end
      if (out_valid) begin
        if ((n == abort_n) && (abort_n >= 0)) begin
          rst_n = 1'b0; out_ready = 1'b0;
          @(negedge clk);
          chk("rst out_valid", out_valid, 0);
          chk("rst busy", busy, 0);
          chk("rst out_data", out_data, 0);
          chk("rst out_last", out_last, 0);
          rst_n = 1'b1;
          for (int k = 0; k < H_LEN; k++) hs[k] = 0;
          return;
        end
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = 1'b1;
          ref_edge = cyc + 1;
          n++;
          seen = 1'b0;
        end
      end
    end
    @(negedge clk);
    out_ready = 1'b0; coef_we = 1'b0;
    chk("out_valid after frame", out_valid, 0);
    chk("busy after frame", busy, 0);
    chk("out_last after frame", out_last, 0);
  endtask

  initial begin
    rst_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_last", out_last, 0);
    chk("reset busy", busy, 0);
    chk("reset in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle in_ready", in_ready, 1);

    // Impulse
    for (int k = 0; k < H_LEN; k++) hs[k] = k + 2;
    for (int i = 0; i < X_LEN; i++) xs[i] = (i == 0) ? 1 : 0;
    load_coefs(); send_frame(X_LEN, 1'b0); recv_frame(-1, 0, 1'b0, 1'b0, -1);

    // All ones
    for (int k = 0; k < H_LEN; k++) hs[k] = 1;
    for (int i = 0; i < X_LEN; i++) xs[i] = 1;
    load_coefs(); send_frame(X_LEN, 1'b0); recv_frame(-1, 0, 1'b0, 1'b0, -1);

    // Max values
    for (int k = 0; k < H_LEN; k++) hs[k] = 15;
    for (int i = 0; i < X_LEN; i++) xs[i] = 15;
    load_coefs(); send_frame(X_LEN, 1'b0); recv_frame(-1, 0, 1'b0, 1'b0, -1);

    // Backpressure on y[3]
    for (int k = 0; k < H_LEN; k++) hs[k] = $urandom_range(0, 15);
    for (int i = 0; i < X_LEN; i++) xs[i] = $urandom_range(0, 15);
    load_coefs(); send_frame(X_LEN, 1'b1); recv_frame(3, 5, 1'b0, 1'b0, -1);

    // Short frame, coefficient write attempted while busy
    for (int k = 0; k < H_LEN; k++) hs[k] = 1;
    xs[0] = 1; xs[1] = 2; xs[2] = 3;
    load_coefs(); send_frame(3, 1'b0); recv_frame(-1, 0, 1'b0, 1'b1, -1);

    // Reset during y[5], then a fresh frame must see zero coefficients
    for (int k = 0; k < H_LEN; k++) hs[k] = $urandom_range(1, 15);
    for (int i = 0; i < X_LEN; i++) xs[i] = $urandom_range(1, 15);
    load_coefs(); send_frame(X_LEN, 1'b0); recv_frame(5, 3, 1'b0, 1'b0, 5);
    for (int i = 0; i < X_LEN; i++) xs[i] = $urandom_range(1, 15);
    send_frame(X_LEN, 1'b0); recv_frame(-1, 0, 1'b0, 1'b0, -1);

    // Random frames
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < H_LEN; k++) hs[k] = $urandom_range(0, 15);
      for (int i = 0; i < X_LEN; i++) xs[i] = $urandom_range(0, 15);
      load_coefs();
      send_frame($urandom_range(1, X_LEN), 1'b1);
      recv_frame(-1, 0, 1'b1, 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_convolver.md
Name: seq_convolver

Overview:
Parametrised, clocked successor to the team's 8x8 4-bit combinational convolver. It accepts a coefficient set through a write port and an input frame of X_LEN samples through a valid/ready stream. It computes the full linear convolution (X_LEN+H_LEN-1 outputs) with a single time-multiplexed MAC, then streams the results out with backpressure. It sits between the sample source and downstream filter/analysis logic in the signal-processing datapath.

Parameters:
DATA_W, 4, input sample width (unsigned)
COEF_W, 4, coefficient width (unsigned)
X_LEN, 8, samples per input frame (>=1)
H_LEN, 8, number of coefficients (>=1)
ACC_W (localparam), DATA_W+COEF_W+$clog2(H_LEN)+1, accumulator/output width; holds the worst-case sum exactly

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(H_LEN)  coefficient index k
coef_data  in  COEF_W  value for h[k]
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  DATA_W  sample x[i]
in_last  in  1  marks final sample of a short frame
out_valid  out  1  out_data holds y[n]
out_ready  in  1  downstream accepts y[n]
out_data  out  ACC_W  convolution result y[n]
out_last  out  1  qualifies y[X_LEN+H_LEN-2]
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; all h[k]=0, all x[i]=0; counters cleared.
  - in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0.
  - Reset mid-frame or mid-output aborts the operation. No partial output after reset.
- States: IDLE, FILL, MAC, EMIT.
- IDLE:
  - coef_we writes h[coef_addr]; coef_addr >= H_LEN is ignored.
  - in_ready=1. The first in_valid handshake stores x[0] and moves to FILL, or to MAC if X_LEN=1 or in_last=1.
- FILL:
  - in_ready=1. Each handshake stores x[i] and increments i.
  - Handshake at i=X_LEN-1, or any handshake with in_last=1, moves to MAC.
  - On early in_last, the remaining x[i+1..X_LEN-1] are zero-filled. The output length is still X_LEN+H_LEN-1.
- coef_we outside IDLE is ignored (coefficients stay frozen for the whole frame).
- MAC, for output index n (starts at 0):
  - acc cleared on entry. One term per cycle for k=0..H_LEN-1: acc += h[k]*x[n-k] when 0<=n-k<X_LEN, else +0.
  - Takes exactly H_LEN cycles. On the cycle after the last term, out_data<=acc, out_valid<=1, state=EMIT.
- EMIT:
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
  - On handshake: if n=X_LEN+H_LEN-2, then out_valid<=0, out_last<=0, state=IDLE. Otherwise n++, out_valid<=0, state=MAC.
- Latency and throughput:
  - First out_valid is asserted H_LEN+1 cycles after the edge accepting the final sample.
  - Each subsequent output takes H_LEN+1 cycles after the previous handshake.
- in_ready=0 in MAC and EMIT. in_valid there is not consumed.
- Arithmetic: unsigned, full precision. No overflow is possible at ACC_W.
- out_ready held high continuously is legal; the block still inserts the MAC gap.

Optional Feature:
Macro CONV_WRAP_COMPAT_EN.
- Defined: out_data[DATA_W-1:0] = y[n] mod 2^DATA_W and upper bits = 0. This reproduces the previous generation's truncating 4-bit accumulation for regression comparison.
- Undefined (default): full ACC_W-bit result.
- Timing and handshake are identical in both builds.

Test Plan:
- Impulse: h=[2,3,4,5,6,7,8,9], x=[1,0,0,0,0,0,0,0] -> y[0..7]=2..9, y[8..14]=0; out_last only on y[14]; first out_valid 9 cycles after the last input edge.
- All-ones: h=x=all 1 -> y=[1,2,3,4,5,6,7,8,7,6,5,4,3,2,1].
- Max values: h=x=all 15 -> y[7]=1800, y[0]=225, y[14]=225. With CONV_WRAP_COMPAT_EN: y[7]=8, y[0]=1.
- Backpressure: out_ready low for 5 cycles on y[3] -> out_data/out_valid stable; no output skipped or duplicated; 15 outputs total.
- Short frame: x=[1,2,3] with in_last on 3, h=all 1 -> y=[1,3,6,6,6,6,6,6,5,3,0,0,0,0,0]; coef_we issued while busy leaves h unchanged.
- Reset mid-EMIT: rst_n=0 one cycle during y[5] -> next cycle out_valid=0, busy=0, h all 0; a new frame then yields all-zero outputs.
